gen192_sendtime: RTL and testbench
==================================

# gen192_sendtime

Testbench traffic generator for the 192-bit PCS data path. It produces the 16×12-bit incrementing-counter pattern and optional send timestamps that the 192-bit receive-side checker validates. It sits at the transmit end of the path, upstream of the DUT, and feeds it through a valid/ready handshake. Programmable word count, inter-word gap and single-word error injection let one bench measure latency and bandwidth and exercise the checker's error detection.

## Interface
- `START_IDX`, default 0: word index loaded at reset and on each `start`; 8 bits.
- `NUM_WORDS`, default 0: number of words sent per run; 0 means run until `stop`.
- `GAP`, default 0: idle cycles inserted after each accepted word; 0 means back-to-back.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a run; honoured in IDLE and DONE only.
- `stop` input 1: abort request, sampled every cycle in RUN and GAP.
- `sendtime` input 1: level; when 1, the word carries a timestamp in bits [35:0].
- `now` input 32: bench time value captured as the timestamp.
- `inject` input 1: pulse; corrupts the next word loaded.
- `ready` input 1: the DUT accepts the word.
- `valid` output 1: `data` holds a word.
- `data` output 192: the generated word.
- `sent_cnt` output 32: count of accepted words in the current run.
- `done` output 1: the run completed or was stopped.

## Operation
- Field i is `data[12i+11:12i]`, for i = 0..15.
- For word index k (8-bit): field i = {k, i[3:0]}, i.e. (16k+i) mod 4096. Field 0 therefore always has low nibble 0, and field 15 of word k is one less than field 0 of word k+1.
- After each accepted word, k increments modulo 256. Word 255 is followed by word 0, so field values wrap from 0xFFF to 0x000.
- Timestamp: if `sendtime` = 1 at the edge where a word is loaded, then `data[31:0]` = `now` and `data[35:32]` = 0, replacing fields 0..2. Fields 3..15 keep the pattern.
- Injection: an `inject` pulse sets a sticky flag. The next word loaded has bit 96 (field 8, bit 0) inverted, and the flag clears at that load. Word index progression is unaffected.
- States and transitions:
  - IDLE → RUN on `start`: load word `START_IDX` and clear `sent_cnt`.
  - RUN → GAP on transfer when `GAP` > 0.
  - RUN → RUN on transfer when `GAP` = 0: load the next word.
  - GAP → RUN when the gap counter reaches `GAP`: load the next word.
  - Any state → DONE when `sent_cnt` reaches `NUM_WORDS` (when `NUM_WORDS` ≠ 0) or on `stop`.
  - DONE → RUN on `start`.
- Transfer occurs when `valid` & `ready` at a rising edge. It increments `sent_cnt`, which saturates at 0xFFFFFFFF.
- `stop` while `valid` & !`ready`: the current word is held until accepted, then the block enters DONE. `stop` in GAP enters DONE immediately. `stop` and transfer in the same cycle: that word counts, then DONE.
- `start` during RUN or GAP is ignored.

## Timing
- Reset (async assert, sync-safe deassert):
  - `valid`, `done` = 0; `data` = 0; `sent_cnt` = 0.
  - k = `START_IDX`; state IDLE; injection flag clear; gap counter 0.
- All outputs are registered; there is no combinational path from `ready` to `valid`.
- `start` at edge N → `valid` = 1 with word `START_IDX` after edge N.
- While `valid` & !`ready`, `data` and `valid` are held stable.
- With `GAP` = 0 and `ready` held high, one word is transferred per cycle with no bubble.
- With `GAP` = G, `valid` stays low for exactly G cycles between words.
- The last transfer at edge M → `valid` = 0 and `done` = 1 after edge M. `done` clears on the edge that accepts `start`.
- `reset_n` asserted mid-run: all outputs go to reset values immediately, and any pending injection is lost.

## Test plan
- Basic pattern:
  - Stimulus: `START_IDX` = 0, `NUM_WORDS` = 4, `ready` = 1, `sendtime` = 0, pulse `start`.
  - Required: 4 back-to-back words with field 0 = 0x000, 0x010, 0x020, 0x030; field 15 of word 0 = 0x00F.
  - Then `done` = 1, `sent_cnt` = 4; the checker flags no words after the first.
- Wrap:
  - Stimulus: `START_IDX` = 254, `NUM_WORDS` = 3.
  - Required: field 0 = 0xFE0, 0xFF0, 0x000; field 15 of the second word = 0xFFF.
- Backpressure and gap:
  - Stimulus: `GAP` = 2, `ready` low for 5 cycles on word 1.
  - Required: word 1 data stable and `valid` high through the stall; exactly 2 idle cycles after each transfer; no word skipped.
- Timestamp:
  - Stimulus: `sendtime` = 1, `now` = 0x00001234 at load.
  - Required: `data[31:0]` = 0x1234, `data[35:32]` = 0, field 3 = 16k+3.
- Injection:
  - Stimulus: pulse `inject` in RUN.
  - Required: exactly the next loaded word has bit 96 inverted, and the checker deasserts `correct` for that word only.
- Stop and reset:
  - Stimulus: `stop` while stalled with `NUM_WORDS` = 0.
  - Required: held word accepted, then `done` = 1.
  - Stimulus: assert `reset_n` = 0 mid-run.
  - Required: `valid` = 0 and `sent_cnt` = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/gen192_sendtime_if.sv
// gen192_sendtime_if
// Valid/ready word bus between the 192-bit pattern generator and the
// device it feeds.
//   valid : generator holds a word on data
//   ready : sink accepts the word on this rising edge
//   data  : 192-bit word, sixteen 12-bit fields
// Modports: master (generator side), slave (sink side).
interface gen192_sendtime_if;
    logic         valid;
    logic         ready;
    logic [191:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gen192_sendtime.sv
// gen192_sendtime
// Transmit-side traffic generator for the 192-bit data path. Each word k
// carries sixteen 12-bit fields, field i = {k, i}, so consecutive fields
// form one continuous counter across words. Optional 36-bit send timestamp
// in the low bits, single-word error injection on bit 96, programmable
// word count and inter-word gap.
// Parameters:
//   START_IDX : word index loaded on reset and on every accepted start
//   NUM_WORDS : words per run, 0 = run until stop
//   GAP       : idle cycles after each accepted word, 0 = back-to-back
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a run (honoured in IDLE/DONE only)
//   stop         : abort request while running
//   sendtime,now : timestamp enable and value, sampled at word load
//   inject       : corrupt bit 96 of the next loaded word
//   bus          : valid/ready/data word bus (master side)
//   sent_cnt     : saturating count of accepted words in the current run
//   done         : run completed or stopped
module gen192_sendtime #(
    parameter logic [7:0]  START_IDX = 8'd0,
    parameter logic [31:0] NUM_WORDS = 32'd0,
    parameter logic [31:0] GAP       = 32'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sendtime,
    input  logic [31:0]          now,
    input  logic                 inject,
    gen192_sendtime_if.master    bus,
    output logic [31:0]          sent_cnt,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [191:0]  data_q, data_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [7:0]    k_q, k_d;
    logic [31:0]   gap_q, gap_d;
    logic          inj_q, inj_d;
    logic          stop_q, stop_d;

    logic          xfer_s;
    logic [31:0]   cnt_inc_s;
    logic          stop_any_s;
    logic          load_s;
    logic [7:0]    load_k_s;

    // Build word k: counter pattern, then optional timestamp overlay, then
    // optional single-bit corruption on field 8 bit 0.
    function automatic logic [191:0] make_word(input logic [7:0]  k,
                                               input logic        ts,
                                               input logic [31:0] t,
                                               input logic        inj);
        logic [191:0] w;
        w = {192{1'b0}};
        for (int i = 0; i < 16; i++) begin
            w[12*i +: 12] = {k, 4'(i)};
        end
        if (ts) begin
            w[35:0] = {4'h0, t};
        end else begin
            w[35:0] = w[35:0];
        end
        if (inj) begin
            w[96] = ~w[96];
        end else begin
            w[96] = w[96];
        end
        return w;
    endfunction

    assign xfer_s    = valid_q & bus.ready;
    assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);

    // Next-state and output-register logic for the run/gap/done sequencer.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        k_d        = k_q;
        gap_d      = gap_q;
        // A pulse landing on a load edge still corrupts that word.
        inj_d      = inj_q | inject;
        stop_d     = stop_q;
        stop_any_s = stop | stop_q;
        load_s     = 1'b0;
        load_k_s   = k_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    load_s   = 1'b1;
                    load_k_s = START_IDX;
                    k_d      = START_IDX;
                    cnt_d    = 32'd0;
                    done_d   = 1'b0;
                    stop_d   = 1'b0;
                    gap_d    = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (xfer_s) begin
                    cnt_d = cnt_inc_s;
                    k_d   = k_q + 8'd1;
                    if (stop_any_s || ((NUM_WORDS != 32'd0) && (cnt_inc_s == NUM_WORDS))) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else if (GAP != 32'd0) begin
                        state_d = S_GAP;
                        valid_d = 1'b0;
                        gap_d   = 32'd0;
                    end else begin
                        load_s   = 1'b1;
                        load_k_s = k_q + 8'd1;
                    end
                end else begin
                    // A stop seen during a stall is remembered until the
                    // held word is finally accepted.
                    stop_d = stop_any_s;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if ((gap_q + 32'd1) == GAP) begin
                    state_d  = S_RUN;
                    load_s   = 1'b1;
                    load_k_s = k_q;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load_s) begin
            valid_d = 1'b1;
            data_d  = make_word(load_k_s, sendtime, now, inj_d);
            inj_d   = 1'b0;
        end else begin
            data_d = data_d;
        end
    end

    // State and output registers; async reset drops outputs immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            data_q  <= {192{1'b0}};
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
            k_q     <= START_IDX;
            gap_q   <= 32'd0;
            inj_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            inj_q   <= inj_d;
            stop_q  <= stop_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.data  = data_q;
    assign sent_cnt  = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gen192_sendtime.sv
// Bench for gen192_sendtime: three instances with different START_IDX /
// NUM_WORDS / GAP share one stimulus stream; each is compared every cycle
// against a behavioural model, plus a vector table and directed sequences.
module tb_gen192_sendtime;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic        stop;
    logic        sendtime;
    logic        inject;
    logic        ready;
    logic [31:0] now;

    gen192_sendtime_if if0();
    gen192_sendtime_if if1();
    gen192_sendtime_if if2();

    assign if0.ready = ready;
    assign if1.ready = ready;
    assign if2.ready = ready;

    logic         v_w    [3];
    logic [191:0] dat_w  [3];
    logic [31:0]  cnt_w  [3];
    logic         done_w [3];

    assign v_w[0] = if0.valid;  assign dat_w[0] = if0.data;
    assign v_w[1] = if1.valid;  assign dat_w[1] = if1.data;
    assign v_w[2] = if2.valid;  assign dat_w[2] = if2.data;

    localparam int P_S [3] = '{0, 254, 5};
    localparam int P_N [3] = '{4, 3, 0};
    localparam int P_G [3] = '{0, 0, 2};

    gen192_sendtime #(.START_IDX(8'd0), .NUM_WORDS(32'd4), .GAP(32'd0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .sendtime(sendtime),
        .now(now), .inject(inject), .bus(if0), .sent_cnt(cnt_w[0]), .done(done_w[0]));
    gen192_sendtime #(.START_IDX(8'd254), .NUM_WORDS(32'd3), .GAP(32'd0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .sendtime(sendtime),
        .now(now), .inject(inject), .bus(if1), .sent_cnt(cnt_w[1]), .done(done_w[1]));
    gen192_sendtime #(.START_IDX(8'd5), .NUM_WORDS(32'd0), .GAP(32'd2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .sendtime(sendtime),
        .now(now), .inject(inject), .bus(if2), .sent_cnt(cnt_w[2]), .done(done_w[2]));

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- behavioural model ----------------
    bit           m_valid [3];
    bit           m_done  [3];
    bit           m_busy  [3];
    bit           m_stop  [3];
    bit           m_inj   [3];
    int           m_k     [3];
    int           m_gap   [3];
    logic [31:0]  m_cnt   [3];
    logic [191:0] m_data  [3];

    function automatic logic [191:0] ref_word(int k, logic ts, logic [31:0] t, logic inj);
        logic [191:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w[12*i +: 12] = 12'((16 * k + i) % 4096);
        if (ts) w[35:0] = {4'h0, t};
        if (inj) w[96] = ~w[96];
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_done[d] = 0; m_busy[d] = 0; m_stop[d] = 0; m_inj[d] = 0;
            m_k[d] = P_S[d]; m_gap[d] = 0; m_cnt[d] = 32'd0; m_data[d] = '0;
        end
    endtask

    task automatic model_load(int d);
        m_data[d]  = ref_word(m_k[d], sendtime, now, m_inj[d]);
        m_inj[d]   = 0;
        m_valid[d] = 1;
    endtask

    task automatic model_edge(int d);
        m_inj[d] = m_inj[d] | inject;
        if (!m_busy[d]) begin
            if (start) begin
                m_k[d] = P_S[d]; m_cnt[d] = 32'd0; m_done[d] = 0; m_busy[d] = 1; m_stop[d] = 0;
                model_load(d);
            end
        end else if (m_valid[d]) begin
            if (ready) begin
                if (m_cnt[d] != 32'hFFFF_FFFF) m_cnt[d] = m_cnt[d] + 32'd1;
                m_k[d] = (m_k[d] + 1) % 256;
                if (stop || m_stop[d] || (P_N[d] != 0 && m_cnt[d] == 32'(P_N[d]))) begin
                    m_valid[d] = 0; m_done[d] = 1; m_busy[d] = 0; m_stop[d] = 0;
                end else if (P_G[d] > 0) begin
                    m_valid[d] = 0; m_gap[d] = P_G[d];
                end else begin
                    model_load(d);
                end
            end else if (stop) begin
                m_stop[d] = 1;
            end
        end else begin
            if (stop) begin
                m_done[d] = 1; m_busy[d] = 0;
            end else begin
                m_gap[d] = m_gap[d] - 1;
                if (m_gap[d] == 0) model_load(d);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [191:0] act, logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_dut(int d);
        check($sformatf("dut%0d valid", d), 192'(v_w[d]), 192'(m_valid[d]));
        check($sformatf("dut%0d done", d), 192'(done_w[d]), 192'(m_done[d]));
        check($sformatf("dut%0d sent_cnt", d), 192'(cnt_w[d]), 192'(m_cnt[d]));
        if (m_valid[d]) check($sformatf("dut%0d data", d), dat_w[d], m_data[d]);
    endtask

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        for (int d = 0; d < 3; d++) check_dut(d);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; sendtime = 1'b0; inject = 1'b0; ready = 1'b0; now = 32'd0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d async rst valid", d), 192'(v_w[d]), 192'(1'b0));
            check($sformatf("dut%0d async rst cnt", d), 192'(cnt_w[d]), 192'(32'd0));
            check($sformatf("dut%0d async rst done", d), 192'(done_w[d]), 192'(1'b0));
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [11:0] exp_f0;
        logic [11:0] exp_f15;
        logic        exp_done;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl [9];
    logic [191:0] held;

    initial begin
        // Basic pattern on dut0 (START_IDX 0, NUM_WORDS 4, GAP 0).
        tbl[0] = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h00F, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 12'h010, 12'h01F, 1'b0, 32'd1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 12'h020, 12'h02F, 1'b0, 32'd2};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 12'h030, 12'h03F, 1'b0, 32'd3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 32'd4};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 32'd4};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 12'h000, 12'h00F, 1'b0, 32'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h00F, 1'b0, 32'd0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 12'h010, 12'h01F, 1'b0, 32'd1};

        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset data", d), dat_w[d], 192'd0);
            check_dut(d);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start;
            ready = tbl[i].ready;
            step();
            check($sformatf("tbl%0d valid", i), 192'(v_w[0]), 192'(tbl[i].exp_valid));
            check($sformatf("tbl%0d done", i), 192'(done_w[0]), 192'(tbl[i].exp_done));
            check($sformatf("tbl%0d cnt", i), 192'(cnt_w[0]), 192'(tbl[i].exp_cnt));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d f0", i), 192'(dat_w[0][11:0]), 192'(tbl[i].exp_f0));
                check($sformatf("tbl%0d f15", i), 192'(dat_w[0][191:180]), 192'(tbl[i].exp_f15));
            end
        end

        // Reset mid-run (dut0 is holding word 1 with sent_cnt 1).
        do_reset();

        // Wrap on dut1 (START_IDX 254, NUM_WORDS 3).
        start = 1'b1; ready = 1'b0;
        step();
        check("wrap f0 w254", 192'(dat_w[1][11:0]), 192'(12'hFE0));
        start = 1'b0; ready = 1'b1;
        step();
        check("wrap f0 w255", 192'(dat_w[1][11:0]), 192'(12'hFF0));
        check("wrap f15 w255", 192'(dat_w[1][191:180]), 192'(12'hFFF));
        step();
        check("wrap f0 w0", 192'(dat_w[1][11:0]), 192'(12'h000));
        step();
        check("wrap done", 192'(done_w[1]), 192'(1'b1));
        check("wrap cnt", 192'(cnt_w[1]), 192'(32'd3));

        // Gap, backpressure and stop-while-stalled on dut2 (START 5, GAP 2).
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        check("gap w5 f0", 192'(dat_w[2][11:0]), 192'(12'h050));
        start = 1'b0;
        step();
        check("gap idle1", 192'(v_w[2]), 192'(1'b0));
        step();
        check("gap idle2", 192'(v_w[2]), 192'(1'b0));
        ready = 1'b0;
        step();
        check("gap w6 valid", 192'(v_w[2]), 192'(1'b1));
        check("gap w6 f0", 192'(dat_w[2][11:0]), 192'(12'h060));
        held = dat_w[2];
        for (int i = 0; i < 5; i++) begin
            stop = (i == 2);
            step();
            check($sformatf("stall%0d valid", i), 192'(v_w[2]), 192'(1'b1));
            check($sformatf("stall%0d data", i), dat_w[2], held);
        end
        stop = 1'b0; ready = 1'b1;
        step();
        check("stop done", 192'(done_w[2]), 192'(1'b1));
        check("stop valid", 192'(v_w[2]), 192'(1'b0));
        check("stop cnt", 192'(cnt_w[2]), 192'(32'd2));

        // Timestamp, then injection on the next load.
        do_reset();
        sendtime = 1'b1; now = 32'h0000_1234; start = 1'b1; ready = 1'b0;
        step();
        check("ts low", 192'(dat_w[0][31:0]), 192'(32'h0000_1234));
        check("ts pad", 192'(dat_w[0][35:32]), 192'(4'h0));
        check("ts f3", 192'(dat_w[0][47:36]), 192'(12'h003));
        check("ts dut2 f3", 192'(dat_w[2][47:36]), 192'(12'h053));
        sendtime = 1'b0; start = 1'b0; inject = 1'b1;
        step();
        inject = 1'b0; ready = 1'b1;
        step();
        check("inj w1 bit96", 192'(dat_w[0][96]), 192'(1'b1));
        check("inj w1 f7", 192'(dat_w[0][95:84]), 192'(12'h017));
        step();
        check("inj w2 bit96", 192'(dat_w[0][96]), 192'(1'b0));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            ready    = ($urandom_range(0, 3) != 0);
            sendtime = 1'($urandom_range(0, 1));
            now      = $urandom;
            inject   = ($urandom_range(0, 15) == 0);
            step();
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
